// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, decoder valid/ready,
// branch redirect and fault flags. master = fetch unit side, slave = memory/decoder/execute side.
interface inst_fetch_unit_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid;
    logic [31:0] imemData;
    logic        instValid;
    logic        instReady;
    logic [31:0] inst;
    logic [31:0] pcOld;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        fetchFault;
    logic        misalignFault;

    modport master (
        output imemReq, imemAddr, instValid, inst, pcOld, fetchFault, misalignFault,
        input  imemValid, imemData, instReady, redirect, redirectPc
    );

    modport slave (
        input  imemReq, imemAddr, instValid, inst, pcOld, fetchFault, misalignFault,
        output imemValid, imemData, instReady, redirect, redirectPc
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Non-pipelined instruction fetch: one request in flight, redirect squashes stale responses.
// Optional FETCH_ALIGN_CHECK_EN: force word-aligned redirect targets and pulse misalignFault.
//
//  state | meaning
//  IDLE  | out of reset, request issued next cycle
//  REQ   | imemReq high for one cycle at imemAddr = pc
//  WAIT  | awaiting imemValid; stale response dropped when discard is set
//  HOLD  | instruction presented to decoder until instReady
//  FAULT | memory timed out; dead until rst
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_unit_if.master   bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] inst_q, inst_nxt;
    logic [31:0] pc_old, pc_old_nxt;
    logic        discard, discard_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;
    logic        fetch_fault, fetch_fault_nxt;
    logic        misalign_q, misalign_nxt;

    logic [31:0] redir_pc;
    logic        redir_misalign;
    logic [7:0]  wait_inc;
    logic        timeout_hit;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_pc       = {bus.redirectPc[31:2], 2'b00};
    assign redir_misalign = |bus.redirectPc[1:0];
`else
    assign redir_pc       = bus.redirectPc;
    assign redir_misalign = 1'b0;
`endif

    assign wait_inc    = wait_cnt + 8'd1;
    assign timeout_hit = (TIMEOUT_CYCLES != 8'd0) && (wait_inc == TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inst_q      <= NOP;
            pc_old      <= RESET_PC;
            discard     <= 1'b0;
            wait_cnt    <= 8'd0;
            fetch_fault <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            inst_q      <= inst_nxt;
            pc_old      <= pc_old_nxt;
            discard     <= discard_nxt;
            wait_cnt    <= wait_cnt_nxt;
            fetch_fault <= fetch_fault_nxt;
            misalign_q  <= misalign_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        inst_nxt        = inst_q;
        pc_old_nxt      = pc_old;
        discard_nxt     = discard;
        wait_cnt_nxt    = wait_cnt;
        fetch_fault_nxt = fetch_fault;
        misalign_nxt    = 1'b0;

        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                state_nxt    = WAIT;
                wait_cnt_nxt = 8'd0;
            end
            WAIT: begin
                if (bus.imemValid) begin
                    if (!discard) begin
                        inst_nxt   = bus.imemData;
                        pc_old_nxt = pc;
                        pc_nxt     = pc + 32'd4;
                        state_nxt  = HOLD;
                    end else begin
                        discard_nxt = 1'b0;
                        state_nxt   = REQ;
                    end
                end else begin
                    wait_cnt_nxt = wait_inc;
                    if (timeout_hit) begin
                        fetch_fault_nxt = 1'b1;
                        state_nxt       = FAULT;
                    end
                end
            end
            HOLD: if (bus.instReady) state_nxt = REQ;
            FAULT: state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase

        // Redirect overrides everything above; a response landing the same cycle is stale
        if (bus.redirect && state != FAULT) begin
            pc_nxt       = redir_pc;
            misalign_nxt = redir_misalign;
            case (state)
                REQ: begin
                    discard_nxt = 1'b1;
                    state_nxt   = WAIT;
                end
                WAIT: begin
                    inst_nxt        = inst_q;
                    pc_old_nxt      = pc_old;
                    fetch_fault_nxt = fetch_fault;
                    wait_cnt_nxt    = wait_cnt;
                    if (bus.imemValid) begin
                        discard_nxt = 1'b0;
                        state_nxt   = REQ;
                    end else begin
                        discard_nxt = 1'b1;
                        state_nxt   = WAIT;
                    end
                end
                default: state_nxt = REQ;
            endcase
        end
    end

    assign bus.imemReq       = (state == REQ);
    assign bus.imemAddr      = pc;
    assign bus.instValid     = (state == HOLD);
    assign bus.inst          = inst_q;
    assign bus.pcOld         = pc_old;
    assign bus.fetchFault    = fetch_fault;
    assign bus.misalignFault = misalign_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: randomized memory latency/redirects/backpressure against a
// transaction-level model, plus a directed wrap/timeout/misalign run on a second instance.
module tb_inst_fetch_unit;
    logic clk = 1'b0;
    logic rst, rst2;
    always #5 clk = ~clk;

    inst_fetch_unit_if bus();
    inst_fetch_unit_if bus2();

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(8'd255)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(8'd4)) u_dut2 (
        .clk(clk), .rst(rst2), .bus(bus2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] target_pc(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    function automatic bit target_misaligned(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
        return t[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Model: next fetch address, the one outstanding request, and the word held for decode
    logic [31:0] exp_pc, out_addr, hold_pc, hold_inst;
    bit          outstanding, out_live, hold_exp, exp_req, exp_mis;
    int          countdown;

    task automatic reset_main();
        @(negedge clk);
        rst = 1'b1;
        bus.imemValid = 1'b0; bus.imemData = '0; bus.instReady = 1'b0;
        bus.redirect = 1'b0;  bus.redirectPc = '0;
        repeat (2) @(negedge clk);
        chk("rst_req",      {31'd0, bus.imemReq},       32'd0);
        chk("rst_addr",     bus.imemAddr,               32'h0);
        chk("rst_valid",    {31'd0, bus.instValid},     32'd0);
        chk("rst_inst",     bus.inst,                   32'h0000_0013);
        chk("rst_pcold",    bus.pcOld,                  32'h0);
        chk("rst_fault",    {31'd0, bus.fetchFault},    32'd0);
        chk("rst_misalign", {31'd0, bus.misalignFault}, 32'd0);
        rst = 1'b0;
        // stray late response during IDLE must be ignored
        bus.imemValid = 1'b1;
        bus.imemData  = $urandom;
        exp_pc = 32'h0; exp_req = 1'b1; hold_exp = 1'b0; outstanding = 1'b0; exp_mis = 1'b0;
    endtask

    task automatic run(input bit calm, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            bit redir, rdy, rsp, nreq, nhold, nmis;
            logic [31:0] tgt;
            @(negedge clk);
            chk("imemReq", {31'd0, bus.imemReq}, {31'd0, exp_req});
            if (exp_req) chk("imemAddr", bus.imemAddr, exp_pc);
            chk("instValid", {31'd0, bus.instValid}, {31'd0, hold_exp});
            if (hold_exp) begin
                chk("pcOld", bus.pcOld, hold_pc);
                chk("inst",  bus.inst,  hold_inst);
            end
            chk("misalignFault", {31'd0, bus.misalignFault}, {31'd0, exp_mis});
            chk("fetchFault",    {31'd0, bus.fetchFault},    32'd0);

            rsp   = outstanding && countdown == 0;
            redir = !calm && ($urandom_range(0, 9) == 0);
            rdy   = calm || ($urandom_range(0, 1) == 1);
            tgt   = $urandom;
            if ($urandom_range(0, 1) == 1) tgt[1:0] = 2'b00;
            bus.imemValid  = rsp || (!calm && !outstanding && $urandom_range(0, 3) == 0);
            bus.imemData   = rsp ? mem_word(out_addr) : $urandom;
            bus.redirect   = redir;
            bus.redirectPc = tgt;
            bus.instReady  = rdy;

            nreq = 1'b0; nhold = hold_exp; nmis = 1'b0;
            if (exp_req) begin
                outstanding = 1'b1;
                out_addr    = exp_pc;
                out_live    = !redir;
                countdown   = calm ? 0 : $urandom_range(0, 3);
            end else if (rsp) begin
                outstanding = 1'b0;
                if (out_live && !redir) begin
                    nhold     = 1'b1;
                    hold_pc   = out_addr;
                    hold_inst = mem_word(out_addr);
                    exp_pc    = out_addr + 32'd4;
                end else begin
                    nreq = 1'b1;
                end
            end else if (outstanding) begin
                countdown--;
                if (redir) out_live = 1'b0;
            end
            if (hold_exp && (redir || rdy)) begin
                nhold = 1'b0;
                nreq  = 1'b1;
            end
            if (redir) begin
                exp_pc = target_pc(tgt);
                nmis   = target_misaligned(tgt);
            end
            exp_req = nreq; hold_exp = nhold; exp_mis = nmis;
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        bus2.imemValid = 1'b0; bus2.imemData = '0; bus2.instReady = 1'b0;
        bus2.redirect = 1'b0;  bus2.redirectPc = '0;

        reset_main();
        run(1'b1, 10);
        run(1'b0, 400);
        reset_main();
        run(1'b0, 400);

        // wrap from 0xFFFFFFFC, then memory goes silent -> timeout after 4 WAIT cycles
        @(negedge clk);
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        chk("w_req1",  {31'd0, bus2.imemReq}, 32'd1);
        chk("w_addr1", bus2.imemAddr, 32'hFFFF_FFFC);
        @(negedge clk);
        bus2.imemValid = 1'b1; bus2.imemData = 32'h1234_5678;
        @(negedge clk);
        bus2.imemValid = 1'b0;
        chk("w_valid", {31'd0, bus2.instValid}, 32'd1);
        chk("w_pcold", bus2.pcOld, 32'hFFFF_FFFC);
        chk("w_inst",  bus2.inst, 32'h1234_5678);
        bus2.instReady = 1'b1;
        @(negedge clk);
        bus2.instReady = 1'b0;
        chk("w_req2",  {31'd0, bus2.imemReq}, 32'd1);
        chk("w_addr2", bus2.imemAddr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_early", {31'd0, bus2.fetchFault}, 32'd0);
        end
        @(negedge clk);
        chk("to_fault", {31'd0, bus2.fetchFault}, 32'd1);
        bus2.redirect = 1'b1; bus2.redirectPc = 32'h40;
        @(negedge clk);
        bus2.redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("f_sticky", {31'd0, bus2.fetchFault}, 32'd1);
            chk("f_noreq",  {31'd0, bus2.imemReq},    32'd0);
            chk("f_noval",  {31'd0, bus2.instValid},  32'd0);
            chk("f_pc",     bus2.imemAddr,            32'h0);
        end

        // reset clears the fault; redirect to 0x102 from IDLE
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("f_clear", {31'd0, bus2.fetchFault}, 32'd0);
        rst2 = 1'b0;
        bus2.redirect = 1'b1; bus2.redirectPc = 32'h102;
        @(negedge clk);
        bus2.redirect = 1'b0;
        chk("m_req", {31'd0, bus2.imemReq}, 32'd1);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("m_addr",  bus2.imemAddr, 32'h100);
        chk("m_pulse", {31'd0, bus2.misalignFault}, 32'd1);
`else
        chk("m_addr",  bus2.imemAddr, 32'h102);
        chk("m_pulse", {31'd0, bus2.misalignFault}, 32'd0);
`endif
        @(negedge clk);
        chk("m_end", {31'd0, bus2.misalignFault}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
